// File: rtl/axis_hdr_arb_pkg.sv
// ---------------------------------------------------------------------------
// axis_hdr_arb_pkg
// Shared types and helpers for the header/payload arbiter in front of the
// axi_stream_insert_header core.
//   - arb_state_e : arbiter FSM states (IDLE, HDR, DATA)
//   - DEF_*       : default sizing used by the arbiter and its sub-blocks
//   - req_wd()    : grant index width for a given requester count
//   - cnt_wd()    : byte-count field width for a given data width
// ---------------------------------------------------------------------------
package axis_hdr_arb_pkg;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_DATA_WD = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2
   } arb_state_e;

   // A single requester still needs a one-bit index.
   function automatic int req_wd(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   // Byte count carries values 0..DATA_BYTE_WD, hence the extra bit.
   function automatic int cnt_wd(input int data_wd);
      return $clog2(data_wd / 8) + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: searches the request vector starting one
// position after last_grant, wrapping modulo NUM_REQ.
// Ports:
//   req        in  NUM_REQ  request vector
//   last_grant in  REQ_WD   most recently served requester
//   winner     out REQ_WD   selected requester (0 when no request)
//   any_req    out 1        at least one request is pending
// ---------------------------------------------------------------------------
module rr_arbiter
   import axis_hdr_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int REQ_WD  = req_wd(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [REQ_WD-1:0]  last_grant,
   output logic [REQ_WD-1:0]  winner,
   output logic               any_req
);

   logic [REQ_WD-1:0] winner_s;
   logic              hit_s;
   int                idx_s;

   // Walk the ring from last_grant+1; the first set request wins.
   always_comb begin
      winner_s = '0;
      hit_s    = 1'b0;
      idx_s    = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx_s    = (int'(last_grant) + i) % NUM_REQ;
         winner_s = (!hit_s && req[idx_s]) ? REQ_WD'(idx_s) : winner_s;
         hit_s    = hit_s | req[idx_s];
      end
   end

   assign winner  = winner_s;
   assign any_req = |req;

endmodule

// File: rtl/axis_insert_header_arbiter.sv
// ---------------------------------------------------------------------------
// axis_insert_header_arbiter
// Shares one axi_stream_insert_header core between NUM_REQ requesters.
// A requester is granted round-robin, its header is forwarded to the insert
// port, then its payload beats are forwarded until the last beat handshakes.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   s_valid_hdr/s_header/s_keep_hdr/
//   s_byte_cnt/s_ready_hdr           per-requester header channels
//   s_valid_in/s_data_in/s_keep_in/
//   s_last_in/s_ready_in             per-requester payload channels
//   m_valid_insert .. m_ready_insert to the core insert port
//   m_valid_in .. m_ready_in         to the core data-in port
//   grant_id                         currently granted requester (registered)
//   busy                             high while a packet is in flight
// ---------------------------------------------------------------------------
module axis_insert_header_arbiter
   import axis_hdr_arb_pkg::*;
#(
   parameter int NUM_REQ      = DEF_NUM_REQ,
   parameter int DATA_WD      = DEF_DATA_WD,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
   parameter int REQ_WD       = req_wd(NUM_REQ)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_REQ-1:0]                s_valid_hdr,
   input  logic [NUM_REQ*DATA_WD-1:0]        s_header,
   input  logic [NUM_REQ*DATA_BYTE_WD-1:0]   s_keep_hdr,
   input  logic [NUM_REQ*(BYTE_CNT_WD+1)-1:0] s_byte_cnt,
   output logic [NUM_REQ-1:0]                s_ready_hdr,
   input  logic [NUM_REQ-1:0]                s_valid_in,
   input  logic [NUM_REQ*DATA_WD-1:0]        s_data_in,
   input  logic [NUM_REQ*DATA_BYTE_WD-1:0]   s_keep_in,
   input  logic [NUM_REQ-1:0]                s_last_in,
   output logic [NUM_REQ-1:0]                s_ready_in,
   output logic                              m_valid_insert,
   output logic [DATA_WD-1:0]                m_header_insert,
   output logic [DATA_BYTE_WD-1:0]           m_keep_insert,
   output logic [BYTE_CNT_WD:0]              m_byte_insert_cnt,
   input  logic                              m_ready_insert,
   output logic                              m_valid_in,
   output logic [DATA_WD-1:0]                m_data_in,
   output logic [DATA_BYTE_WD-1:0]           m_keep_in,
   output logic                              m_last_in,
   input  logic                              m_ready_in,
   output logic [REQ_WD-1:0]                 grant_id,
   output logic                              busy
);

   localparam int CNT_WD = BYTE_CNT_WD + 1;

   arb_state_e        state_r;
   logic [REQ_WD-1:0] grant_r;
   logic [REQ_WD-1:0] last_grant_r;
   logic              busy_r;
   logic [REQ_WD-1:0] winner_s;
   logic              any_req_s;
   logic              hdr_hs_s;
   logic              pkt_done_s;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .REQ_WD  (REQ_WD)
   ) u_rr_arbiter (
      .req        (s_valid_hdr),
      .last_grant (last_grant_r),
      .winner     (winner_s),
      .any_req    (any_req_s)
   );

   assign hdr_hs_s   = m_valid_insert & m_ready_insert;
   assign pkt_done_s = m_valid_in & m_ready_in & m_last_in;

   // Arbiter FSM; requests are only looked at in IDLE so a packet is never
   // pre-empted, and the round-robin pointer moves only on packet completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         grant_r      <= '0;
         last_grant_r <= REQ_WD'(NUM_REQ - 1);
         busy_r       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (any_req_s) begin
                  grant_r <= winner_s;
                  busy_r  <= 1'b1;
                  state_r <= HDR;
               end
            end
            HDR: begin
               if (hdr_hs_s) begin
                  state_r <= DATA;
               end
            end
            DATA: begin
               if (pkt_done_s) begin
                  last_grant_r <= grant_r;
                  busy_r       <= 1'b0;
                  state_r      <= IDLE;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Steer the granted requester onto the core ports. Only the channel that
   // matches the current phase is opened, which keeps payload behind header.
   always_comb begin
      m_valid_insert    = 1'b0;
      m_header_insert   = '0;
      m_keep_insert     = '0;
      m_byte_insert_cnt = '0;
      m_valid_in        = 1'b0;
      m_data_in         = '0;
      m_keep_in         = '0;
      m_last_in         = 1'b0;
      s_ready_hdr       = '0;
      s_ready_in        = '0;
      case (state_r)
         HDR: begin
            m_valid_insert       = s_valid_hdr[grant_r];
            m_header_insert      = s_header[int'(grant_r)*DATA_WD +: DATA_WD];
            m_keep_insert        = s_keep_hdr[int'(grant_r)*DATA_BYTE_WD +: DATA_BYTE_WD];
            m_byte_insert_cnt    = s_byte_cnt[int'(grant_r)*CNT_WD +: CNT_WD];
            s_ready_hdr[grant_r] = m_ready_insert;
         end
         DATA: begin
            m_valid_in          = s_valid_in[grant_r];
            m_data_in           = s_data_in[int'(grant_r)*DATA_WD +: DATA_WD];
            m_keep_in           = s_keep_in[int'(grant_r)*DATA_BYTE_WD +: DATA_BYTE_WD];
            m_last_in           = s_last_in[grant_r];
            s_ready_in[grant_r] = m_ready_in;
         end
         default: begin
            m_valid_insert = 1'b0;
            m_valid_in     = 1'b0;
         end
      endcase
   end

   assign grant_id = grant_r;
   assign busy     = busy_r;

endmodule

// File: tb/tb_axis_insert_header_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_insert_header_arbiter
// Self-checking bench: per-requester packet queues drive the slave side,
// and a packet-level reference model predicts every core-side output and
// slave-side ready each cycle.
// ---------------------------------------------------------------------------
module tb_axis_insert_header_arbiter;

   localparam int NR   = 4;
   localparam int DW   = 32;
   localparam int BW   = 4;
   localparam int CW   = 3;
   localparam int RW   = 2;
   localparam int MAXP = 128;
   localparam int MAXB = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR-1:0]     s_valid_hdr, s_ready_hdr, s_valid_in, s_last_in, s_ready_in;
   logic [NR*DW-1:0]  s_header, s_data_in;
   logic [NR*BW-1:0]  s_keep_hdr, s_keep_in;
   logic [NR*CW-1:0]  s_byte_cnt;
   logic              m_valid_insert, m_ready_insert, m_valid_in, m_last_in, m_ready_in;
   logic [DW-1:0]     m_header_insert, m_data_in;
   logic [BW-1:0]     m_keep_insert, m_keep_in;
   logic [CW-1:0]     m_byte_insert_cnt;
   logic [RW-1:0]     grant_id;
   logic              busy;

   always #5 clk = ~clk;

   axis_insert_header_arbiter #(
      .NUM_REQ (NR),
      .DATA_WD (DW)
   ) u_dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .s_valid_hdr       (s_valid_hdr),
      .s_header          (s_header),
      .s_keep_hdr        (s_keep_hdr),
      .s_byte_cnt        (s_byte_cnt),
      .s_ready_hdr       (s_ready_hdr),
      .s_valid_in        (s_valid_in),
      .s_data_in         (s_data_in),
      .s_keep_in         (s_keep_in),
      .s_last_in         (s_last_in),
      .s_ready_in        (s_ready_in),
      .m_valid_insert    (m_valid_insert),
      .m_header_insert   (m_header_insert),
      .m_keep_insert     (m_keep_insert),
      .m_byte_insert_cnt (m_byte_insert_cnt),
      .m_ready_insert    (m_ready_insert),
      .m_valid_in        (m_valid_in),
      .m_data_in         (m_data_in),
      .m_keep_in         (m_keep_in),
      .m_last_in         (m_last_in),
      .m_ready_in        (m_ready_in),
      .grant_id          (grant_id),
      .busy              (busy)
   );

   // packet store
   logic [DW-1:0] pk_hdr  [MAXP];
   logic [BW-1:0] pk_hkeep[MAXP];
   logic [CW-1:0] pk_cnt  [MAXP];
   int            pk_len  [MAXP];
   logic [DW-1:0] pk_d    [MAXP][MAXB];
   logic [BW-1:0] pk_k    [MAXP][MAXB];
   int            n_pk = 0;
   int            req_q[NR][$];

   // requester driver state
   bit hdr_sent[NR];
   int beat[NR];
   bit pv[NR];
   int gap[NR];

   // policies
   int ins_hold  = 0;
   bit rins_rand = 1'b0;
   bit rin_rand  = 1'b0;
   int pay_pct   = 100;
   int gap_max   = 0;

   // reference model: 0 idle, 1 header phase, 2 payload phase
   int m_st   = 0;
   int m_g    = 0;
   int m_last = NR - 1;
   int glog[$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
   endtask

   function automatic int rr_pick(input int last, input logic [NR-1:0] v);
      for (int k = 1; k <= NR; k++) begin
         if (v[(last + k) % NR]) return (last + k) % NR;
      end
      return -1;
   endfunction

   function automatic bit all_done();
      for (int r = 0; r < NR; r++) if (req_q[r].size() != 0) return 1'b0;
      return (m_st == 0);
   endfunction

   task automatic add_pkt(input int r, input int len, input logic [DW-1:0] h,
                          input logic [BW-1:0] hk, input logic [CW-1:0] c,
                          input logic [BW-1:0] lk);
      pk_hdr[n_pk]   = h;
      pk_hkeep[n_pk] = hk;
      pk_cnt[n_pk]   = c;
      pk_len[n_pk]   = len;
      for (int b = 0; b < len; b++) begin
         pk_d[n_pk][b] = $urandom;
         pk_k[n_pk][b] = (b == len - 1) ? lk : 4'hF;
      end
      req_q[r].push_back(n_pk);
      n_pk++;
   endtask

   task automatic clear_bench();
      for (int r = 0; r < NR; r++) begin
         req_q[r].delete();
         hdr_sent[r] = 1'b0;
         beat[r]     = 0;
         pv[r]       = 1'b0;
         gap[r]      = 0;
      end
      m_st = 0; m_g = 0; m_last = NR - 1;
      glog.delete();
      s_valid_hdr = '0; s_header = '0; s_keep_hdr = '0; s_byte_cnt = '0;
      s_valid_in = '0; s_data_in = '0; s_keep_in = '0; s_last_in = '0;
      m_ready_insert = 1'b0; m_ready_in = 1'b0;
   endtask

   task automatic drive();
      for (int r = 0; r < NR; r++) begin
         int p;
         bit act;
         p   = (req_q[r].size() > 0) ? req_q[r][0] : -1;
         act = (p >= 0) && (gap[r] == 0);
         if (gap[r] > 0) gap[r]--;
         if (act && !pv[r] && ($urandom_range(99) < pay_pct)) pv[r] = 1'b1;
         if (act) begin
            s_valid_hdr[r]           = !hdr_sent[r];
            s_header[r*DW +: DW]     = pk_hdr[p];
            s_keep_hdr[r*BW +: BW]   = pk_hkeep[p];
            s_byte_cnt[r*CW +: CW]   = pk_cnt[p];
            s_valid_in[r]            = pv[r];
            s_data_in[r*DW +: DW]    = pk_d[p][beat[r]];
            s_keep_in[r*BW +: BW]    = pk_k[p][beat[r]];
            s_last_in[r]             = (beat[r] == pk_len[p] - 1);
         end else begin
            s_valid_hdr[r]           = 1'b0;
            s_header[r*DW +: DW]     = '0;
            s_keep_hdr[r*BW +: BW]   = '0;
            s_byte_cnt[r*CW +: CW]   = '0;
            s_valid_in[r]            = 1'b0;
            s_data_in[r*DW +: DW]    = '0;
            s_keep_in[r*BW +: BW]    = '0;
            s_last_in[r]             = 1'b0;
         end
      end
      if (ins_hold > 0) m_ready_insert = 1'b0;
      else m_ready_insert = rins_rand ? 1'($urandom_range(1)) : 1'b1;
      m_ready_in = rin_rand ? 1'($urandom_range(1)) : 1'b1;
   endtask

   // compare DUT against the model, then advance the model past the coming edge
   task automatic check_model();
      logic [NR-1:0] e_rh, e_ri;
      logic          e_vh, e_vd, e_l;
      logic [DW-1:0] e_h, e_d;
      logic [BW-1:0] e_hk, e_k;
      logic [CW-1:0] e_c;
      int            p;
      e_rh = '0; e_ri = '0; e_vh = 1'b0; e_vd = 1'b0; e_l = 1'b0;
      e_h = '0; e_d = '0; e_hk = '0; e_k = '0; e_c = '0;
      p = -1;
      if (m_st != 0) p = req_q[m_g][0];
      if (m_st == 1) begin
         e_vh = s_valid_hdr[m_g];
         e_h = pk_hdr[p]; e_hk = pk_hkeep[p]; e_c = pk_cnt[p];
         e_rh[m_g] = m_ready_insert;
      end
      if (m_st == 2) begin
         e_vd = pv[m_g];
         e_d = pk_d[p][beat[m_g]]; e_k = pk_k[p][beat[m_g]];
         e_l = (beat[m_g] == pk_len[p] - 1);
         e_ri[m_g] = m_ready_in;
      end
      chk("busy",        64'(busy),              64'(m_st != 0));
      chk("grant_id",    64'(grant_id),          64'(m_g));
      chk("valid_ins",   64'(m_valid_insert),    64'(e_vh));
      chk("header",      64'(m_header_insert),   64'(e_h));
      chk("keep_ins",    64'(m_keep_insert),     64'(e_hk));
      chk("cnt_ins",     64'(m_byte_insert_cnt), 64'(e_c));
      chk("valid_in",    64'(m_valid_in),        64'(e_vd));
      chk("data_in",     64'(m_data_in),         64'(e_d));
      chk("keep_in",     64'(m_keep_in),         64'(e_k));
      chk("last_in",     64'(m_last_in),         64'(e_l));
      chk("ready_hdr",   64'(s_ready_hdr),       64'(e_rh));
      chk("ready_in",    64'(s_ready_in),        64'(e_ri));
      case (m_st)
         0: begin
            if (s_valid_hdr != '0) begin
               m_g = rr_pick(m_last, s_valid_hdr);
               glog.push_back(m_g);
               m_st = 1;
            end
         end
         1: begin
            if (s_valid_hdr[m_g] && m_ready_insert) begin
               hdr_sent[m_g] = 1'b1;
               m_st = 2;
            end
            if (ins_hold > 0) ins_hold--;
         end
         default: begin
            if (pv[m_g] && m_ready_in) begin
               pv[m_g] = 1'b0;
               if (beat[m_g] == pk_len[p] - 1) begin
                  void'(req_q[m_g].pop_front());
                  hdr_sent[m_g] = 1'b0;
                  beat[m_g] = 0;
                  gap[m_g] = $urandom_range(gap_max);
                  m_last = m_g;
                  m_st = 0;
               end else begin
                  beat[m_g]++;
               end
            end
         end
      endcase
   endtask

   task automatic cycle();
      @(negedge clk);
      drive();
      #1;
      check_model();
   endtask

   task automatic run_until_done(input string tag, input int budget);
      int n;
      n = 0;
      while (!all_done() && n < budget) begin
         cycle();
         n++;
      end
      chk(tag, 64'(all_done()), 64'd1);
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_busy"},  64'(busy),           64'd0);
      chk({tag, "_gid"},   64'(grant_id),       64'd0);
      chk({tag, "_vins"},  64'(m_valid_insert), 64'd0);
      chk({tag, "_vin"},   64'(m_valid_in),     64'd0);
      chk({tag, "_rhdr"},  64'(s_ready_hdr),    64'd0);
      chk({tag, "_rin"},   64'(s_ready_in),     64'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_bench();
      repeat (2) @(negedge clk);
      #1;
      check_quiet("reset");
      rst_n = 1'b1;
   endtask

   int exp_order[5] = '{0, 1, 2, 3, 0};
   int n_wait;

   initial begin
      do_reset();

      // single requester, 3-beat packet
      add_pkt(0, 3, 32'hA5A5_A5A5, 4'b0011, 3'd2, 4'hF);
      run_until_done("t1_drain", 100);
      chk("t1_grants", 64'(glog.size()), 64'd1);
      chk("t1_grant0", 64'(glog[0]), 64'd0);

      // everyone at once after reset: 0,1,2,3 then 0 again
      do_reset();
      for (int r = 0; r < NR; r++) add_pkt(r, 2, $urandom, 4'hF, 3'd4, 4'hF);
      add_pkt(0, 1, $urandom, 4'h1, 3'd1, 4'h1);
      run_until_done("t2_drain", 200);
      chk("t2_grants", 64'(glog.size()), 64'd5);
      for (int i = 0; i < 5; i++) chk("t2_order", 64'(glog[i]), 64'(exp_order[i]));

      // payload valid early, header held off for 5 cycles
      glog.delete();
      ins_hold = 5;
      add_pkt(2, 3, $urandom, 4'h7, 3'd3, 4'h3);
      run_until_done("t3_drain", 100);
      chk("t3_grant", 64'(glog[0]), 64'd2);

      // throttled payload
      glog.delete();
      rin_rand = 1'b1;
      add_pkt(1, 5, $urandom, 4'hF, 3'd4, 4'h1);
      run_until_done("t4_drain", 200);
      rin_rand = 1'b0;

      // single-beat packet
      glog.delete();
      add_pkt(3, 1, $urandom, 4'h8, 3'd1, 4'b1000);
      run_until_done("t5_drain", 50);
      chk("t5_grant", 64'(glog[0]), 64'd3);

      // reset in the middle of req 1 payload
      add_pkt(1, 5, $urandom, 4'hF, 3'd4, 4'hF);
      n_wait = 0;
      while (!(m_st == 2 && m_g == 1 && beat[1] >= 1) && n_wait < 100) begin
         cycle();
         n_wait++;
      end
      chk("t6_reach", 64'(m_st == 2 && m_g == 1), 64'd1);
      @(negedge clk);
      drive();
      #2 rst_n = 1'b0;
      #1;
      check_quiet("t6_async");
      clear_bench();
      @(negedge clk);
      rst_n = 1'b1;
      add_pkt(1, 2, $urandom, 4'hF, 3'd4, 4'hF);
      add_pkt(0, 2, $urandom, 4'hF, 3'd4, 4'hF);
      run_until_done("t6_drain", 100);
      chk("t6_first", 64'(glog[0]), 64'd0);
      chk("t6_second", 64'(glog[1]), 64'd1);

      // randomized traffic
      rins_rand = 1'b1;
      rin_rand  = 1'b1;
      pay_pct   = 60;
      gap_max   = 3;
      for (int i = 0; i < 40; i++) begin
         add_pkt(int'($urandom_range(NR - 1)), int'($urandom_range(6, 1)), $urandom,
                 4'($urandom), 3'($urandom), 4'($urandom_range(15, 1)));
      end
      run_until_done("rand_drain", 5000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/axis_insert_header_arbiter.md
Name: axis_insert_header_arbiter

Overview:
- Shares one axi_stream_insert_header instance between NUM_REQ independent requesters.
- Each requester owns a header channel (header, keep, byte count) and a payload AXI-Stream channel.
- The arbiter grants one requester in round-robin order, forwards its header to the insert port, then forwards its payload beats until the last beat is handshaken.
- Sits directly upstream of the insert core: its m_* ports connect to the core's data-in and insert ports.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_WD, 32: data/header width in bits.
- DATA_BYTE_WD, DATA_WD/8: keep width.
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD): byte-count width minus 1.
- REQ_WD, $clog2(NUM_REQ): grant index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid_hdr  in  NUM_REQ  per-requester header valid.
- s_header  in  NUM_REQ*DATA_WD  headers; requester i at slice [i*DATA_WD +: DATA_WD].
- s_keep_hdr  in  NUM_REQ*DATA_BYTE_WD  header keep.
- s_byte_cnt  in  NUM_REQ*(BYTE_CNT_WD+1)  header byte count.
- s_ready_hdr  out  NUM_REQ  header ready.
- s_valid_in  in  NUM_REQ  payload valid.
- s_data_in  in  NUM_REQ*DATA_WD  payload data.
- s_keep_in  in  NUM_REQ*DATA_BYTE_WD  payload keep.
- s_last_in  in  NUM_REQ  payload last.
- s_ready_in  out  NUM_REQ  payload ready.
- m_valid_insert  out  1  to core valid_insert.
- m_header_insert  out  DATA_WD  to core header_insert.
- m_keep_insert  out  DATA_BYTE_WD  to core keep_insert.
- m_byte_insert_cnt  out  BYTE_CNT_WD+1  to core byte_insert_cnt.
- m_ready_insert  in  1  from core ready_insert.
- m_valid_in  out  1  to core valid_in.
- m_data_in  out  DATA_WD  to core data_in.
- m_keep_in  out  DATA_BYTE_WD  to core keep_in.
- m_last_in  out  1  to core last_in.
- m_ready_in  in  1  from core ready_in.
- grant_id  out  REQ_WD  currently granted requester; registered.
- busy  out  1  high in HDR or DATA.

Behaviour:
- FSM states:
  - IDLE: if any s_valid_hdr is set, register the winner into grant_id and go to HDR on the next edge; otherwise stay in IDLE.
  - HDR: leave for DATA on m_valid_insert && m_ready_insert.
  - DATA: return to IDLE on m_valid_in && m_ready_in && m_last_in.
- Arbitration:
  - Round-robin search starting at last_grant+1, wrapping modulo NUM_REQ.
  - last_grant is updated only when a packet completes (DATA->IDLE).
  - Requests are sampled only in IDLE; a requester raising valid mid-packet waits.
- Muxing:
  - HDR: m_valid_insert=s_valid_hdr[g], m_header_insert/m_keep_insert/m_byte_insert_cnt = slice g, s_ready_hdr[g]=m_ready_insert.
  - DATA: m_valid_in/data/keep/last = slice g, s_ready_in[g]=m_ready_in.
  - Both muxes are combinational from the registered grant, zero added latency.
- Gating:
  - All non-granted s_ready_hdr/s_ready_in = 0.
  - s_ready_in[g]=0 in HDR, so payload never precedes its header.
  - m_valid_insert=0 outside HDR; m_valid_in=0 outside DATA.
  - m_* data fields read 0 whenever the corresponding valid is forced 0.
- Latency: header request in IDLE -> m_valid_insert high 1 cycle later. There is one IDLE bubble cycle between packets.
- Single-beat packet (last on first beat): DATA->IDLE after that one handshake.
- Granted header valid deasserting before handshake (protocol violation): stay in HDR; no regrant.
- byte_insert_cnt and keep pass through unmodified; no range check.
- Reset:
  - Asynchronous; state=IDLE, grant_id=0, last_grant=NUM_REQ-1 (requester 0 wins first), busy=0, all readies and valids 0.
  - Reset mid-packet abandons the packet; requesters must resend.

Decomposition:
- Package axis_hdr_arb_pkg: state enum (IDLE, HDR, DATA), REQ_WD and slice-width helper constants.
- Sub-module rr_arbiter:
  - Inputs: NUM_REQ-wide request vector, last_grant pointer.
  - Outputs: combinational winner index and any_req.
  - Reused elsewhere.

Test Plan:
- Req 0 only; header 0xA5A5A5A5, keep 4'b0011, cnt 2; 3-beat payload -> m_valid_insert 1 cycle after request, header passes unchanged, 3 beats on m_*_in, last on beat 3, grant_id=0, then IDLE.
- All 4 requesters request simultaneously after reset -> grant order 0,1,2,3, then 0 again; one IDLE cycle between packets.
- Req 2 payload valid asserted before its header is accepted, m_ready_insert held 0 for 5 cycles -> s_ready_in[2]=0 throughout, m_valid_in=0; payload flows only after header handshake.
- Random m_ready_in throttling (50%) during a 5-beat packet from req 1 -> every beat appears exactly once in order, data/keep/last stable while stalled.
- Single-beat packet from req 3 (last=1, keep 4'b1000) -> one header handshake plus one data handshake, return to IDLE.
- rst_n pulsed low mid-DATA of req 1 -> all valids and readies drop asynchronously, busy=0; after release, req 0 and req 1 requesting -> req 0 granted.
